// File: rtl/kb_pkg.sv
// kb_pkg: shared constants for the PS/2 set-2 keyboard front-end.
//   - Decoder FSM state encodings (IDLE, BREAK, EXT, EXT_BREAK).
//   - Scan-code constants for prefixes, modifier keys and resync codes.
//   - ASCII constants and a helper that spots resync/error bytes.
package kb_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_BREAK     = 2'd1;
    localparam logic [1:0] ST_EXT       = 2'd2;
    localparam logic [1:0] ST_EXT_BREAK = 2'd3;

    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_LSHIFT   = 8'h12;
    localparam logic [7:0] SC_RSHIFT   = 8'h59;
    localparam logic [7:0] SC_CAPS     = 8'h58;
    localparam logic [7:0] SC_KP_ENTER = 8'h5A;
    localparam logic [7:0] SC_BAT      = 8'hAA;
    localparam logic [7:0] SC_BAT_ERR  = 8'hFC;
    localparam logic [7:0] SC_ERR_LO   = 8'h00;
    localparam logic [7:0] SC_ERR_HI   = 8'hFF;

    localparam logic [6:0] ASCII_CR = 7'h0D;

    // Self-test / error bytes mean the keyboard restarted: resynchronise the decoder.
    function automatic logic is_resync(input logic [7:0] code);
        return (code == SC_BAT) || (code == SC_BAT_ERR) ||
               (code == SC_ERR_LO) || (code == SC_ERR_HI);
    endfunction

endpackage

// File: rtl/ps2_ascii_map.sv
// ps2_ascii_map: combinational PS/2 set-2 make code to 7-bit ASCII lookup.
//   code  in  8  make code (prefixes already stripped)
//   shift in  1  shift held
//   caps  in  1  caps lock active
//   ascii out 7  mapped character, 0 for unmapped codes
// Letters honour shift XOR caps; digits and punctuation honour shift only.
module ps2_ascii_map (
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    output logic [6:0] ascii
);

    logic [6:0] lc;      // lowercase letter, 0 if not a letter
    logic [6:0] sym_lo;  // unshifted symbol
    logic [6:0] sym_hi;  // shifted symbol

    always_comb begin
        lc     = 7'h00;
        sym_lo = 7'h00;
        sym_hi = 7'h00;
        case (code)
            8'h1C: lc = 7'h61;  8'h32: lc = 7'h62;  8'h21: lc = 7'h63;  8'h23: lc = 7'h64;
            8'h24: lc = 7'h65;  8'h2B: lc = 7'h66;  8'h34: lc = 7'h67;  8'h33: lc = 7'h68;
            8'h43: lc = 7'h69;  8'h3B: lc = 7'h6A;  8'h42: lc = 7'h6B;  8'h4B: lc = 7'h6C;
            8'h3A: lc = 7'h6D;  8'h31: lc = 7'h6E;  8'h44: lc = 7'h6F;  8'h4D: lc = 7'h70;
            8'h15: lc = 7'h71;  8'h2D: lc = 7'h72;  8'h1B: lc = 7'h73;  8'h2C: lc = 7'h74;
            8'h3C: lc = 7'h75;  8'h2A: lc = 7'h76;  8'h1D: lc = 7'h77;  8'h22: lc = 7'h78;
            8'h35: lc = 7'h79;  8'h1A: lc = 7'h7A;
            8'h16: begin sym_lo = 7'h31; sym_hi = 7'h21; end
            8'h1E: begin sym_lo = 7'h32; sym_hi = 7'h40; end
            8'h26: begin sym_lo = 7'h33; sym_hi = 7'h23; end
            8'h25: begin sym_lo = 7'h34; sym_hi = 7'h24; end
            8'h2E: begin sym_lo = 7'h35; sym_hi = 7'h25; end
            8'h36: begin sym_lo = 7'h36; sym_hi = 7'h5E; end
            8'h3D: begin sym_lo = 7'h37; sym_hi = 7'h26; end
            8'h3E: begin sym_lo = 7'h38; sym_hi = 7'h2A; end
            8'h46: begin sym_lo = 7'h39; sym_hi = 7'h28; end
            8'h45: begin sym_lo = 7'h30; sym_hi = 7'h29; end
            8'h4E: begin sym_lo = 7'h2D; sym_hi = 7'h5F; end
            8'h55: begin sym_lo = 7'h3D; sym_hi = 7'h2B; end
            8'h54: begin sym_lo = 7'h5B; sym_hi = 7'h7B; end
            8'h5B: begin sym_lo = 7'h5D; sym_hi = 7'h7D; end
            8'h5D: begin sym_lo = 7'h5C; sym_hi = 7'h7C; end
            8'h4C: begin sym_lo = 7'h3B; sym_hi = 7'h3A; end
            8'h52: begin sym_lo = 7'h27; sym_hi = 7'h22; end
            8'h41: begin sym_lo = 7'h2C; sym_hi = 7'h3C; end
            8'h49: begin sym_lo = 7'h2E; sym_hi = 7'h3E; end
            8'h4A: begin sym_lo = 7'h2F; sym_hi = 7'h3F; end
            8'h0E: begin sym_lo = 7'h60; sym_hi = 7'h7E; end
            8'h29: begin sym_lo = 7'h20; sym_hi = 7'h20; end
            8'h66: begin sym_lo = 7'h08; sym_hi = 7'h08; end
            8'h0D: begin sym_lo = 7'h09; sym_hi = 7'h09; end
            default: ;
        endcase

        if (lc != 7'h00) begin
            // Lowercase and uppercase differ only in bit 5.
            ascii = {lc[6], lc[5] & ~(shift ^ caps), lc[4:0]};
        end else begin
            ascii = shift ? sym_hi : sym_lo;
        end
    end

endmodule

// File: rtl/kb_scan_fifo.sv
// kb_scan_fifo: PS/2 set-2 scan-code decoder feeding a show-ahead ASCII FIFO.
//   clk, rst_n              clock, asynchronous active-low reset
//   ps2_byte/ps2_byte_valid scan-code byte and one-cycle strobe
//   kb_read_en              pop head entry (one pop per cycle held high)
//   kb_clear                synchronous flush of FIFO and overflow flag
//   kb_status               FIFO non-empty
//   kb_data                 ASCII at head, 0 when empty
//   buf_full, kb_count      full flag and occupancy
//   kb_overflow             sticky, set on any push into a full FIFO
// Parameters: DEPTH (power of two, 2..256), OVERFLOW_MODE (0 drop new, 1 overwrite oldest).
// Build option: define KB_TYPEMATIC_FILTER_EN to suppress auto-repeated make codes.
module kb_scan_fifo
    import kb_pkg::*;
#(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned OVERFLOW_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               ps2_byte,
    input  logic                     ps2_byte_valid,
    input  logic                     kb_read_en,
    input  logic                     kb_clear,
    output logic                     kb_status,
    output logic [6:0]               kb_data,
    output logic                     buf_full,
    output logic [$clog2(DEPTH):0]   kb_count,
    output logic                     kb_overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // ---------------- decoder ----------------
    logic [1:0] state_q, state_d;
    logic       shift_q, shift_d;
    logic       caps_q, caps_d;
    logic [6:0] map_ascii;
    logic       push_req;
    logic [6:0] push_char;

    ps2_ascii_map u_map (
        .code  (ps2_byte),
        .shift (shift_q),
        .caps  (caps_q),
        .ascii (map_ascii)
    );

`ifdef KB_TYPEMATIC_FILTER_EN
    logic [7:0] last_make_q, last_make_d;
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        caps_d    = caps_q;
        push_req  = 1'b0;
        push_char = map_ascii;
`ifdef KB_TYPEMATIC_FILTER_EN
        last_make_d = last_make_q;
`endif
        if (ps2_byte_valid) begin
            if (is_resync(ps2_byte)) begin
                state_d = ST_IDLE;
                shift_d = 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (ps2_byte == SC_BREAK) begin
                            state_d = ST_BREAK;
                        end else if (ps2_byte == SC_EXT) begin
                            state_d = ST_EXT;
                        end else if (ps2_byte == SC_LSHIFT || ps2_byte == SC_RSHIFT) begin
                            shift_d = 1'b1;
                        end else if (ps2_byte == SC_CAPS) begin
                            caps_d = ~caps_q;
                        end else if (map_ascii != 7'h00) begin
`ifdef KB_TYPEMATIC_FILTER_EN
                            if (ps2_byte != last_make_q) begin
                                push_req    = 1'b1;
                                last_make_d = ps2_byte;
                            end
`else
                            push_req = 1'b1;
`endif
                        end
                    end
                    ST_BREAK: begin
                        if (ps2_byte == SC_LSHIFT || ps2_byte == SC_RSHIFT) begin
                            shift_d = 1'b0;
                        end
`ifdef KB_TYPEMATIC_FILTER_EN
                        // Releasing the repeating key re-arms it for the next press.
                        if (ps2_byte == last_make_q) begin
                            last_make_d = 8'h00;
                        end
`endif
                        state_d = ST_IDLE;
                    end
                    ST_EXT: begin
                        if (ps2_byte == SC_BREAK) begin
                            state_d = ST_EXT_BREAK;
                        end else begin
                            state_d = ST_IDLE;
                            if (ps2_byte == SC_KP_ENTER) begin
                                push_req  = 1'b1;
                                push_char = ASCII_CR;
                            end
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // ---------------- FIFO ----------------
    logic [6:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             mem_we;
    logic             full, empty, pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign pop   = kb_read_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        mem_we   = 1'b0;
        if (kb_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else if (push_req && pop) begin
            // When full, wr_ptr == rd_ptr: the slot written is the one being popped.
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else if (push_req && !full) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d  = count_q + CNT_W'(1);
        end else if (push_req) begin
            ovf_d = 1'b1;
            if (OVERFLOW_MODE != 0) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= push_char;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shift_q  <= 1'b0;
            caps_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            caps_q   <= caps_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef KB_TYPEMATIC_FILTER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_make_q <= 8'h00;
        end else begin
            last_make_q <= last_make_d;
        end
    end
`endif

    assign kb_status   = !empty;
    assign kb_data     = empty ? 7'h00 : mem_q[rd_ptr_q];
    assign buf_full    = full;
    assign kb_count    = count_q;
    assign kb_overflow = ovf_q;

endmodule

// File: tb/tb_kb_scan_fifo.sv
module tb_kb_scan_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ps2_byte = 8'h00;
    logic       ps2_byte_valid = 1'b0;
    logic       kb_read_en = 1'b0;
    logic       kb_clear = 1'b0;

    logic       st0, st1, full0, full1, ovf0, ovf1;
    logic [6:0] data0, data1;
    logic [2:0] cnt0, cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboards: mode 0 (drop new) and mode 1 (overwrite oldest), both DEPTH 4.
    logic [6:0] q0[$];
    logic [6:0] q1[$];
    logic       exp_ovf0 = 1'b0;
    logic       exp_ovf1 = 1'b0;

    always #5 clk = ~clk;

    kb_scan_fifo #(.DEPTH(4), .OVERFLOW_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ps2_byte(ps2_byte), .ps2_byte_valid(ps2_byte_valid),
        .kb_read_en(kb_read_en), .kb_clear(kb_clear), .kb_status(st0), .kb_data(data0),
        .buf_full(full0), .kb_count(cnt0), .kb_overflow(ovf0)
    );

    kb_scan_fifo #(.DEPTH(4), .OVERFLOW_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ps2_byte(ps2_byte), .ps2_byte_valid(ps2_byte_valid),
        .kb_read_en(kb_read_en), .kb_clear(kb_clear), .kb_status(st1), .kb_data(data1),
        .buf_full(full1), .kb_count(cnt1), .kb_overflow(ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        ps2_byte = b;
        ps2_byte_valid = 1'b1;
        @(negedge clk);
        ps2_byte_valid = 1'b0;
    endtask

    task automatic exp_push(input logic [6:0] c);
        if (q0.size() < 4) q0.push_back(c);
        else exp_ovf0 = 1'b1;
        if (q1.size() < 4) begin
            q1.push_back(c);
        end else begin
            void'(q1.pop_front());
            q1.push_back(c);
            exp_ovf1 = 1'b1;
        end
    endtask

    task automatic exp_flush();
        q0.delete();
        q1.delete();
        exp_ovf0 = 1'b0;
        exp_ovf1 = 1'b0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_cnt0"}, 32'(cnt0), 32'(q0.size()));
        chk({tag, "_cnt1"}, 32'(cnt1), 32'(q1.size()));
        chk({tag, "_st0"}, 32'(st0), 32'(q0.size() != 0));
        chk({tag, "_ovf0"}, 32'(ovf0), 32'(exp_ovf0));
        chk({tag, "_ovf1"}, 32'(ovf1), 32'(exp_ovf1));
        chk({tag, "_full0"}, 32'(full0), 32'(q0.size() == 4));
        chk({tag, "_head0"}, 32'(data0), (q0.size() != 0) ? 32'(q0[0]) : 32'h0);
        chk({tag, "_head1"}, 32'(data1), (q1.size() != 0) ? 32'(q1[0]) : 32'h0);
    endtask

    // Compare heads against the scoreboard, pop one entry, repeat until empty.
    task automatic drain(input string tag);
        while (q0.size() != 0 || q1.size() != 0) begin
            chk({tag, "_head0"}, 32'(data0), (q0.size() != 0) ? 32'(q0[0]) : 32'h0);
            chk({tag, "_head1"}, 32'(data1), (q1.size() != 0) ? 32'(q1[0]) : 32'h0);
            @(negedge clk);
            kb_read_en = 1'b1;
            @(negedge clk);
            kb_read_en = 1'b0;
            if (q0.size() != 0) void'(q0.pop_front());
            if (q1.size() != 0) void'(q1.pop_front());
        end
        chk({tag, "_empty0"}, 32'(st0), 32'h0);
        chk({tag, "_empty1"}, 32'(st1), 32'h0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Plain make/break of 'a'.
        send(8'h1C); send(8'hF0); send(8'h1C);
        exp_push(7'h61);
        chk_state("a_make");
        drain("a_pop");

        // Shifted then unshifted 'a'.
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h12); send(8'h1C);
        exp_push(7'h41);
        exp_push(7'h61);
        chk_state("shift_a");
        drain("shift_pop");

        // Caps on, 'a' -> 'A'; shift+caps -> 'a'; shift+'1' -> '!'.
        send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
        exp_push(7'h41);
        send(8'h12); send(8'h1C);
`ifndef KB_TYPEMATIC_FILTER_EN
        exp_push(7'h61);
`endif
        chk_state("caps");
        drain("caps_pop");
        send(8'h16);
        exp_push(7'h21);
        drain("shift_digit");
        send(8'hF0); send(8'h16);
        send(8'hF0); send(8'h12);
        send(8'h58); send(8'hF0); send(8'h58);

        // Auto-repeat without break.
        send(8'h1C); send(8'h1C); send(8'h1C);
        exp_push(7'h61);
`ifndef KB_TYPEMATIC_FILTER_EN
        exp_push(7'h61);
        exp_push(7'h61);
`endif
        chk_state("repeat");
        drain("repeat_pop");
        send(8'hF0); send(8'h1C);

        // Overflow: five distinct letters into a 4-entry FIFO.
        send(8'h1C); send(8'hF0); send(8'h1C); exp_push(7'h61);
        send(8'h32); send(8'hF0); send(8'h32); exp_push(7'h62);
        send(8'h21); send(8'hF0); send(8'h21); exp_push(7'h63);
        send(8'h23); send(8'hF0); send(8'h23); exp_push(7'h64);
        chk_state("fill");
        send(8'h24); send(8'hF0); send(8'h24); exp_push(7'h65);
        chk_state("overflow");
        chk("ovf_head0_a", 32'(data0), 32'h61);
        chk("ovf_head1_b", 32'(data1), 32'h62);

        // Push and pop together while full: count stays, no new state change in mode 0.
        @(negedge clk);
        ps2_byte = 8'h2B; ps2_byte_valid = 1'b1; kb_read_en = 1'b1;
        @(negedge clk);
        ps2_byte_valid = 1'b0; kb_read_en = 1'b0;
        void'(q0.pop_front()); q0.push_back(7'h66);
        void'(q1.pop_front()); q1.push_back(7'h66);
        chk_state("full_push_pop");
        send(8'hF0); send(8'h2B);

        // Clear.
        @(negedge clk); kb_clear = 1'b1;
        @(negedge clk); kb_clear = 1'b0;
        exp_flush();
        chk_state("clear");

        // Clear coincident with a push leaves the FIFO empty.
        @(negedge clk);
        ps2_byte = 8'h1C; ps2_byte_valid = 1'b1; kb_clear = 1'b1;
        @(negedge clk);
        ps2_byte_valid = 1'b0; kb_clear = 1'b0;
        chk_state("clear_push");
        send(8'hF0); send(8'h1C);

        // Resync byte clears shift: 12, AA, 1C -> 'a'.
        send(8'h12); send(8'hAA); send(8'h1C);
        exp_push(7'h61);
        chk_state("resync");
        drain("resync_pop");
        send(8'hF0); send(8'h1C);

        // Reset between E0 and 5A: decoder back in IDLE, 5A alone is unmapped.
        send(8'hE0);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        exp_flush();
        send(8'h5A);
        chk_state("rst_mid_ext");

        // Keypad Enter, then its extended break must not push.
        send(8'hE0); send(8'h5A);
        exp_push(7'h0D);
        send(8'hE0); send(8'hF0); send(8'h5A);
        chk_state("kp_enter");
        drain("kp_enter_pop");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/kb_scan_fifo.md
# kb_scan_fifo

Parametrised keyboard front-end that turns a stream of PS/2 set-2 scan-code bytes into 7-bit ASCII characters.

- Tracks make/break/extended prefixes and Shift/Caps modifier state.
- Queues characters in a configurable-depth FIFO read by the Y86 core through a read-enable/status handshake.
- Sits between the PS/2 byte receiver and the CPU I/O port.
- Replaces the single-entry keyboard path with a true multi-entry buffer, overflow reporting and case handling.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- OVERFLOW_MODE, 0, 0 = drop new character when full, 1 = overwrite oldest.

Ports:
- clk  in  1  master clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ps2_byte  in  8  received scan-code byte.
- ps2_byte_valid  in  1  one-cycle strobe, ps2_byte valid.
- kb_read_en  in  1  pop head entry.
- kb_clear  in  1  synchronous flush of FIFO and overflow flag.
- kb_status  out  1  FIFO non-empty.
- kb_data  out  7  ASCII at FIFO head (show-ahead); 0 when empty.
- buf_full  out  1  count == DEPTH.
- kb_count  out  $clog2(DEPTH)+1  current occupancy.
- kb_overflow  out  1  sticky; set on any full-FIFO push.

## Operation
**Reset.**
- All outputs 0.
- FSM in IDLE; shift, caps and last_make cleared.

**Decoder FSM.** Advances only on cycles where ps2_byte_valid = 1.
- IDLE:
  - 0xF0 goes to BREAK; 0xE0 goes to EXT.
  - 0x12 or 0x59 sets shift, no push.
  - 0x58 toggles caps, no push.
  - Any other byte is looked up. Push if the mapped value is non-zero and not filtered.
- BREAK:
  - 0x12 or 0x59 clears shift.
  - If byte == last_make, clear last_make.
  - Return to IDLE; never push.
- EXT:
  - 0xF0 goes to EXT_BREAK.
  - 0x5A pushes 0x0D (keypad Enter).
  - Any other byte is dropped. Return to IDLE.
- EXT_BREAK: any byte returns to IDLE.
- From any state, 0xAA, 0xFC, 0x00 or 0xFF forces IDLE and clears shift. Caps is held.

**Case mapping.**
- Letters use shift XOR caps.
- Digits and punctuation use shift only.
- Unmapped codes map to 0 and are never pushed.

**FIFO.**
- Read and write pointers are $clog2(DEPTH) bits wide and wrap naturally.
- kb_count is a separate counter.

**Priority within one cycle:** kb_clear > push/pop.
- Clear: empty the FIFO, clear kb_overflow, leave FSM and modifier state untouched.
- Pop with kb_read_en when empty is ignored.
- Push and pop together: both occur, count unchanged. This also applies when full, with no overflow.
- Push when full with no pop:
  - Mode 0: character discarded, kb_overflow = 1.
  - Mode 1: oldest entry discarded, read pointer advances, count stays DEPTH, kb_overflow = 1.

## Timing
- Byte strobe at edge N updates FSM and FIFO at edge N. kb_status and kb_data reflect the new entry after edge N (1-cycle latency).
- kb_read_en sampled at edge M; kb_data shows the next entry after edge M.
- The CPU must deassert kb_read_en after one cycle per character. A level held for k cycles pops k entries.
- Back-to-back byte strobes are legal, one byte per cycle.
- rst_n assertion mid-operation immediately clears all state. Deassertion must be synchronised externally.

## Configuration
KB_TYPEMATIC_FILTER_EN:
- Defined: a make code equal to last_make is not pushed, which suppresses auto-repeat. last_make updates on every pushed make.
- Undefined: every make code is pushed; last_make logic is absent.

## Structure
- Shared package kb_pkg holds:
  - FSM state enum (IDLE, BREAK, EXT, EXT_BREAK).
  - Scan-code constants (F0, E0, LSHIFT 0x12, RSHIFT 0x59, CAPS 0x58, KP_ENTER 0x5A, BAT 0xAA).
  - ASCII CR constant.
- One sub-module, ps2_ascii_map: combinational lookup (code, shift, caps) to 7-bit ASCII.
- FIFO storage and pointers are inline.

## Test plan
- Reset, then bytes 1C, F0, 1C: kb_status = 1, kb_data = 0x61, kb_count = 1. Pulse kb_read_en: kb_status = 0.
- 12, 1C, F0, 1C, F0, 12, 1C: FIFO holds 0x41 then 0x61.
- 58, F0, 58, 1C, then 12, 1C: 0x41 then 0x61 (caps XOR shift). 12, 16 gives 0x21.
- DEPTH = 4, push 5 distinct letters:
  - Mode 0: head still the first character, count = 4, kb_overflow = 1.
  - Mode 1: head is the second character.
  - kb_clear: count 0, overflow 0.
- 1C, 1C, 1C with no break: one 0x61 with KB_TYPEMATIC_FILTER_EN defined, three without.
- Edge cases:
  - kb_clear coincident with a push gives an empty FIFO.
  - rst_n low between E0 and 5A: no push follows.
  - E0 5A after reset gives 0x0D.
